// File: rtl/frame_buf_rd_ctrl.sv
// Frame buffer read-side master.
// Issues one active-low read strobe per frame word, never letting reads in
// flight plus buffered words exceed the skid FIFO depth. Variable-latency
// return data is absorbed in that FIFO and handed to the consumer as a
// valid/ready word stream.
module frame_buf_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 6,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_l,
    output logic                  fb_rd_en_l,
    input  logic                  fb_rd_valid,
    input  logic [DATA_WIDTH-1:0] fb_rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_WIDTH-1:0] FRAME_END = CNT_WIDTH'(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0]     DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_WIDTH-1:0]  req_cnt_r;
    logic [CNT_WIDTH-1:0]  out_cnt_r;
    logic [OCC_W-1:0]      outstanding_r;
    logic [OCC_W-1:0]      fifo_cnt_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic                  fb_rd_en_l_r;
    logic                  err_r;

    logic                  start_s;
    logic                  frame_start_s;
    logic                  credit_ok_s;
    logic                  issue_s;
    logic                  busy_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  last_xfer_s;
    logic [OCC_W:0]        credit_sum_s;

    // Credit uses registered occupancy only: reads in flight plus buffered words.
    assign credit_sum_s  = {1'b0, outstanding_r} + {1'b0, fifo_cnt_r};
    assign credit_ok_s   = (credit_sum_s < {1'b0, DEPTH_OCC});
    assign start_s       = ~start_l;
    assign frame_start_s = (state_r == ST_IDLE) & start_s;

    // A return is only accepted against an outstanding read and a free slot.
    assign push_s      = fb_rd_valid & (outstanding_r != {OCC_W{1'b0}}) & (fifo_cnt_r != DEPTH_OCC);
    assign pix_valid   = (fifo_cnt_r != {OCC_W{1'b0}});
    assign pop_s       = pix_valid & pix_ready;
    assign last_xfer_s = pop_s & (state_r != ST_IDLE) & (out_cnt_r == LAST_IDX);

    assign pix_data   = mem_r[rd_ptr_r];
    assign fb_rd_en_l = fb_rd_en_l_r;
    assign busy       = busy_s;
    assign frame_done = last_xfer_s;
    assign err        = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave FETCH once the final request has been issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (CNT_WIDTH'(issue_s) == FRAME_END) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_xfer_s) begin
                    state_nxt_s = ST_IDLE;
                end else if ((req_cnt_r + CNT_WIDTH'(issue_s)) == FRAME_END) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (last_xfer_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: issue_s decides whether the strobe is low next cycle.
    always_comb begin
        issue_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                issue_s = start_s & credit_ok_s;
                busy_s  = 1'b0;
            end
            ST_FETCH: begin
                issue_s = (req_cnt_r < FRAME_END) & credit_ok_s;
                busy_s  = 1'b1;
            end
            ST_DRAIN: begin
                issue_s = 1'b0;
                busy_s  = 1'b1;
            end
            default: begin
                issue_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Registered read strobe and sticky return-protocol error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fb_rd_en_l_r <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            fb_rd_en_l_r <= ~issue_s;
            err_r        <= err_r | (fb_rd_valid & ~push_s);
        end
    end

    // Request/transfer word counters and outstanding-read count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_cnt_r     <= {CNT_WIDTH{1'b0}};
            out_cnt_r     <= {CNT_WIDTH{1'b0}};
            outstanding_r <= {OCC_W{1'b0}};
        end else begin
            if (frame_start_s) begin
                req_cnt_r <= CNT_WIDTH'(issue_s);
                out_cnt_r <= {CNT_WIDTH{1'b0}};
            end else begin
                req_cnt_r <= req_cnt_r + CNT_WIDTH'(issue_s);
                if (pop_s && (state_r != ST_IDLE)) begin
                    out_cnt_r <= out_cnt_r + CNT_ONE;
                end else begin
                    out_cnt_r <= out_cnt_r;
                end
            end
            outstanding_r <= outstanding_r + OCC_W'(issue_s) - OCC_W'(push_s);
        end
    end

    // Skid FIFO storage, pointers and explicit occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {OCC_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= fb_rd_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

endmodule

// File: tb/tb_frame_buf_rd_ctrl.sv
// Self-checking bench for frame_buf_rd_ctrl: cycle-exact vector tables for the
// nominal frame and back-to-back frames, hand sequences for backpressure,
// reset and error corners, and randomized frames against a word-level model.
module tb_frame_buf_rd_ctrl;
    localparam int DW = 32;
    localparam int FL = 6;
    localparam int CW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_l;
    logic          fb_rd_en_l;
    logic          fb_rd_valid;
    logic [DW-1:0] fb_rd_data;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic          frame_done;
    logic          err;

    always #5 clk = ~clk;

    frame_buf_rd_ctrl #(
        .DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .start_l(start_l), .fb_rd_en_l(fb_rd_en_l),
        .fb_rd_valid(fb_rd_valid), .fb_rd_data(fb_rd_data), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    typedef struct {
        logic          s;
        logic          v;
        logic [DW-1:0] d;
        logic          en;
        logic          pv;
        logic [DW-1:0] pd;
        logic          bz;
        logic          fd;
    } row_t;

    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            lat = 1;
    int            strobes = 0;
    int            xfers = 0;
    int            dones = 0;
    int            frame_x0 = 0;
    logic          hold_chk = 1'b0;
    logic [DW-1:0] last_pd = '0;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    logic [DW-1:0] exp_q[$];
    row_t          t2[10];
    row_t          t6[10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dword(input int k);
        return 32'hC0DE_0000 + DW'(k);
    endfunction

    function automatic row_t mk(input logic s, input logic v, input logic [DW-1:0] d, input logic en,
                                input logic pv, input logic [DW-1:0] pd, input logic bz, input logic fd);
        row_t r;
        r.s = s; r.v = v; r.d = d; r.en = en; r.pv = pv; r.pd = pd; r.bz = bz; r.fd = fd;
        return r;
    endfunction

    function automatic logic rdy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b0;
    endfunction

    task automatic drive(input logic s, input logic r, input logic v, input logic [DW-1:0] d);
        start_l = s; pix_ready = r; fb_rd_valid = v; fb_rd_data = d;
        #1;
    endtask

    task automatic apply_row(input row_t rw, input string tag);
        drive(rw.s, 1'b1, rw.v, rw.d);
        check({tag, ".en_l"}, fb_rd_en_l, rw.en);
        check({tag, ".pix_valid"}, pix_valid, rw.pv);
        if (rw.pv) check({tag, ".pix_data"}, pix_data, rw.pd);
        check({tag, ".busy"}, busy, rw.bz);
        check({tag, ".frame_done"}, frame_done, rw.fd);
        check({tag, ".err"}, err, 1'b0);
        @(negedge clk);
    endtask

    // One cycle with the bench acting as an in-order frame buffer and consumer.
    task automatic tick(input logic s, input logic r);
        logic          v;
        logic [DW-1:0] d;
        int            due;
        v = 1'b0;
        d = '0;
        if (due_q.size() > 0) begin
            if (due_q[0] == cyc) begin
                v   = 1'b1;
                d   = dat_q.pop_front();
                due = due_q.pop_front();
            end
        end
        drive(s, r, v, d);
        if (hold_chk) begin
            check("hold_valid", pix_valid, 1'b1);
            check("hold_data", pix_data, last_pd);
        end
        if (fb_rd_en_l === 1'b0) begin
            d   = $urandom;
            due = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 4)));
            if (due_q.size() > 0) begin
                if (due <= due_q[$]) due = due_q[$] + 1;
            end
            due_q.push_back(due);
            dat_q.push_back(d);
            exp_q.push_back(d);
            strobes++;
            check("credit", exp_q.size() <= FD, 1'b1);
        end
        if (pix_valid && pix_ready) begin
            xfers++;
            check("xfer_queue", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("xfer_data", pix_data, exp_q.pop_front());
        end
        if (frame_done) begin
            dones++;
            check("done_xfer", pix_valid && pix_ready, 1'b1);
            check("done_pos", xfers - frame_x0, FL);
        end
        hold_chk = pix_valid && !pix_ready;
        last_pd  = pix_data;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_frame(input int latency, input int mode, input string tag);
        int s0, x0, d0;
        lat = latency; s0 = strobes; x0 = xfers; d0 = dones; frame_x0 = xfers;
        tick(1'b0, rdy(mode));
        for (int k = 0; k < 400; k++) begin
            if (dones != d0) break;
            tick(1'b1, rdy(mode));
        end
        check({tag, ".done_once"}, dones - d0, 1);
        check({tag, ".strobes"}, strobes - s0, FL);
        check({tag, ".xfers"}, xfers - x0, FL);
        check({tag, ".busy_after"}, busy, 1'b0);
        check({tag, ".err"}, err, 1'b0);
    endtask

    task automatic do_reset;
        reset = 1'b0; start_l = 1'b1; fb_rd_valid = 1'b0; pix_ready = 1'b0; fb_rd_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        due_q.delete(); dat_q.delete(); exp_q.delete();
        hold_chk = 1'b0;
    endtask

    initial begin
        int s0, x0, d0;
        reset = 1'b0; start_l = 1'b1; pix_ready = 1'b0; fb_rd_valid = 1'b0; fb_rd_data = '0;
        repeat (3) @(negedge clk);
        check("rst.en_l", fb_rd_en_l, 1'b1);
        check("rst.pix_valid", pix_valid, 1'b0);
        check("rst.pix_data", pix_data, 32'h0);
        check("rst.busy", busy, 1'b0);
        check("rst.frame_done", frame_done, 1'b0);
        check("rst.err", err, 1'b0);
        reset = 1'b1;

        // Nominal frame, latency 1, consumer always ready.
        t2[0] = mk(1'b0, 1'b0, '0,       1'b1, 1'b0, '0,       1'b0, 1'b0);
        t2[1] = mk(1'b1, 1'b0, '0,       1'b0, 1'b0, '0,       1'b1, 1'b0);
        t2[2] = mk(1'b1, 1'b1, dword(0), 1'b0, 1'b0, '0,       1'b1, 1'b0);
        t2[3] = mk(1'b1, 1'b1, dword(1), 1'b0, 1'b1, dword(0), 1'b1, 1'b0);
        t2[4] = mk(1'b1, 1'b1, dword(2), 1'b0, 1'b1, dword(1), 1'b1, 1'b0);
        t2[5] = mk(1'b1, 1'b1, dword(3), 1'b0, 1'b1, dword(2), 1'b1, 1'b0);
        t2[6] = mk(1'b1, 1'b1, dword(4), 1'b0, 1'b1, dword(3), 1'b1, 1'b0);
        t2[7] = mk(1'b1, 1'b1, dword(5), 1'b1, 1'b1, dword(4), 1'b1, 1'b0);
        t2[8] = mk(1'b1, 1'b0, '0,       1'b1, 1'b1, dword(5), 1'b1, 1'b1);
        t2[9] = mk(1'b1, 1'b0, '0,       1'b1, 1'b0, '0,       1'b0, 1'b0);
        // Second frame started right after frame_done, start_l pulsed in DRAIN.
        t6    = t2;
        t6[7].s = 1'b0;

        for (int i = 0; i < 9; i++) apply_row(t2[i], $sformatf("T2[%0d]", i));
        for (int i = 0; i < 9; i++) apply_row(t6[i], $sformatf("T6[%0d]", i));
        apply_row(t2[9], "T6[9]");
        apply_row(t2[9], "T6[10]");

        // Consumer stalled: credit limits strobes to the FIFO depth.
        lat = 1; s0 = strobes; x0 = xfers; frame_x0 = xfers; d0 = dones;
        tick(1'b0, 1'b0);
        for (int k = 0; k < 14; k++) tick(1'b1, 1'b0);
        check("T3.strobes_held", strobes - s0, FD);
        check("T3.en_l_high", fb_rd_en_l, 1'b1);
        check("T3.pix_valid", pix_valid, 1'b1);
        check("T3.head_D0", pix_data, exp_q[0]);
        check("T3.busy", busy, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (dones != d0) break;
            tick(1'b1, 1'b1);
        end
        check("T3.done_once", dones - d0, 1);
        check("T3.strobes", strobes - s0, FL);
        check("T3.xfers", xfers - x0, FL);
        check("T3.busy_after", busy, 1'b0);

        run_frame(3, 1, "T4");
        run_frame(1, 0, "B2B");
        for (int f = 0; f < 12; f++) begin
            run_frame(0, 2, $sformatf("RND%0d", f));
            repeat ($urandom_range(0, 3)) tick(1'b1, rdy(2));
        end
        run_frame(4, 0, "LAT4");

        // Reset with two reads in flight; their late returns must flag err.
        lat = 5;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        reset = 1'b0;
        tick(1'b1, 1'b1);
        check("T1.en_l", fb_rd_en_l, 1'b1);
        check("T1.pix_valid", pix_valid, 1'b0);
        check("T1.pix_data", pix_data, 32'h0);
        check("T1.busy", busy, 1'b0);
        check("T1.frame_done", frame_done, 1'b0);
        check("T1.err", err, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b1);
        check("T1.err_late", err, 1'b1);
        check("T1.fifo_empty", pix_valid, 1'b0);
        check("T1.idle", busy, 1'b0);

        // Stray return while idle.
        do_reset();
        check("T5.err_cleared", err, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        fb_rd_valid = 1'b0;
        check("T5.err_set", err, 1'b1);
        check("T5.pix_valid", pix_valid, 1'b0);
        repeat (3) @(negedge clk);
        check("T5.err_sticky", err, 1'b1);
        check("T5.still_empty", pix_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
